// File: rtl/wb_stream_pkg.sv
// Shared constants and types for the Wishbone byte-stream output port.
package wb_stream_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RXIN   = 2'd3;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_BUSY    = 3;
  localparam int ST_COUNT   = 4;
  localparam int ST_COUNT_W = 5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/wb_stream_out_if.sv
// Wishbone classic slave bundle for wb_stream_out.
// Handshake: the master holds cyc/stb/adr/we/dat/sel stable until it sees ack; ack is a one-cycle pulse.
interface wb_stream_out_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO; a push when full is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_stream_out.sv
// Wishbone-written TX FIFO drained to pins with a 4-phase strobe/ack handshake,
// plus status/control registers, a synchronized input-pin sample and a level interrupt.
module wb_stream_out
  import wb_stream_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  wb_stream_out_if.slave    wb,
  output logic [7:0]        tx_data_o,
  output logic              tx_stb_o,
  input  logic              tx_ack_i,
  input  logic [7:0]        rx_pins_i,
  output logic [8:0]        tx_oeb_o,
  output logic              irq_o,
  output tx_state_t         dbg_state_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            ack_s1, ack_sync;
  logic [7:0]      rx_s1, rx_sync;
  logic            ack_q;
  logic [31:0]     dat_q;
  logic            en_q, irq_en_q, ovf_q;
  tx_state_t       state_q;

  logic            hit, wr, rd;
  logic [1:0]      reg_sel;
  logic            push_req, fifo_pop;
  logic [7:0]      fifo_dout;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [31:0]     rd_data;
  logic            unused_bits;

  assign unused_bits = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:8], wb.wbs_sel_i[3:1]};

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_s1   <= 1'b0;
      ack_sync <= 1'b0;
      rx_s1    <= '0;
      rx_sync  <= '0;
    end else begin
      ack_s1   <= tx_ack_i;
      ack_sync <= ack_s1;
      rx_s1    <= rx_pins_i;
      rx_sync  <= rx_s1;
    end
  end

  // Gating on ack_q keeps a held request from being decoded twice.
  assign hit      = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q &
                    (wb.wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign wr       = hit & wb.wbs_we_i;
  assign rd       = hit & ~wb.wbs_we_i;
  assign reg_sel  = wb.wbs_adr_i[3:2];
  assign push_req = wr & (reg_sel == REG_TXDATA) & wb.wbs_sel_i[0];
  assign fifo_pop = (state_q == IDLE) & en_q & ~fifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (wb.wbs_dat_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_STATUS: begin
        rd_data[ST_EMPTY] = fifo_empty;
        rd_data[ST_FULL]  = fifo_full;
        rd_data[ST_OVF]   = ovf_q;
        rd_data[ST_BUSY]  = (state_q != IDLE);
        rd_data[ST_COUNT +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
      end
      REG_CTRL: begin
        rd_data[CTRL_EN]     = en_q;
        rd_data[CTRL_IRQ_EN] = irq_en_q;
      end
      REG_RXIN: rd_data[7:0] = rx_sync;
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ack_q <= hit;
      dat_q <= rd ? rd_data : '0;
      if (wr && reg_sel == REG_CTRL && wb.wbs_sel_i[0]) begin
        en_q     <= wb.wbs_dat_i[CTRL_EN];
        irq_en_q <= wb.wbs_dat_i[CTRL_IRQ_EN];
      end
      // A drop only happens when no pop frees a slot in the same cycle.
      if (push_req && fifo_full && !fifo_pop)
        ovf_q <= 1'b1;
      else if (wr && reg_sel == REG_STATUS && wb.wbs_sel_i[0] && wb.wbs_dat_i[ST_OVF])
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      tx_data_o <= '0;
      tx_stb_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (fifo_pop) begin
          tx_data_o <= fifo_dout;
          tx_stb_o  <= 1'b1;
          state_q   <= REQ;
        end
        REQ: if (ack_sync) begin
          tx_stb_o <= 1'b0;
          state_q  <= REL;
        end
        REL: if (!ack_sync) state_q <= IDLE;
        default: begin
          tx_stb_o <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign tx_oeb_o     = {9{~en_q}};
  assign irq_o        = irq_en_q & (ovf_q | (fifo_empty & (state_q == IDLE)));
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_wb_stream_out.sv
// Bench for wb_stream_out: directed register/handshake scenarios plus random byte traffic
// checked against a queue model of the bytes that must appear on the pins.
module tb_wb_stream_out;
  import wb_stream_pkg::*;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_stream_out_if wb();
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       tx_ack;
  logic [7:0] rx_pins;
  logic [8:0] tx_oeb;
  logic       irq;
  tx_state_t  dbg_state;

  wb_stream_out #(.DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .wb          (wb.slave),
    .tx_data_o   (tx_data),
    .tx_stb_o    (tx_stb),
    .tx_ack_i    (tx_ack),
    .rx_pins_i   (rx_pins),
    .tx_oeb_o    (tx_oeb),
    .irq_o       (irq),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [7:0] exp_q[$];
  bit  model_en  = 1'b0;
  bit  model_ovf = 1'b0;
  int  n_checks  = 0;
  int  n_err     = 0;
  bit  peer_on   = 1'b1;
  int  peer_delay = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_of(input int cnt, input bit ovf, input bit busy);
    logic [31:0] s;
    s = '0;
    s[0] = (cnt == 0);
    s[1] = (cnt == DEPTH);
    s[2] = ovf;
    s[3] = busy;
    s[8:4] = 5'(cnt);
    return s;
  endfunction

  function automatic logic [31:0] reg_adr(input logic [1:0] r);
    return BASE | {28'h0, r, 2'b00};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;  wb.wbs_sel_i = sel;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!wb.wbs_ack_o && waited < 4);
    rdata = wb.wbs_dat_o;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    check("wb_ack_latency", 32'(waited), 32'd1);
  endtask

  task automatic wb_write(input logic [1:0] r, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_xfer(1'b1, reg_adr(r), dat, sel, dummy);
  endtask

  task automatic wb_read(input logic [1:0] r, output logic [31:0] dat);
    wb_xfer(1'b0, reg_adr(r), 32'h0, 4'hF, dat);
  endtask

  task automatic set_ctrl(input logic [1:0] v);
    wb_write(REG_CTRL, {30'h0, v}, 4'h1);
    model_en = v[0];
  endtask

  task automatic push_byte(input logic [7:0] b, input logic [3:0] sel);
    wb_write(REG_TXDATA, {24'($urandom), b}, sel);
    if (sel[0]) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else model_ovf = 1'b1;
    end
  endtask

  task automatic wait_drained(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || tx_stb || tx_ack) && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check("drain_timeout", 32'(i < budget), 32'd1);
    repeat (4) @(posedge clk);
  endtask

  // ---------------- external peer ----------------
  initial begin
    int pcnt;
    pcnt = 0;
    tx_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        tx_ack = 1'b0; pcnt = 0;
      end else if (peer_on) begin
        if (!tx_ack && tx_stb) begin
          if (pcnt >= peer_delay) begin tx_ack = 1'b1; pcnt = 0; end else pcnt++;
        end else if (tx_ack && !tx_stb) begin
          if (pcnt >= peer_delay) begin tx_ack = 1'b0; pcnt = 0; end else pcnt++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    bit prev_stb;
    logic [7:0] held;
    int cyc_cnt, last_rise;
    prev_stb = 1'b0; held = '0; cyc_cnt = 0; last_rise = -100;
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (rst_n) begin
        check("oeb", 32'(tx_oeb), 32'({9{~model_en}}));
        if (!wb.wbs_ack_o) check("dat_idle_zero", wb.wbs_dat_o, 32'h0);
        if (tx_stb && !prev_stb) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
          end else begin
            check("tx_byte_order", 32'(tx_data), 32'(exp_q.pop_front()));
          end
          check("byte_period_min6", 32'(cyc_cnt - last_rise >= 6), 32'd1);
          last_rise = cyc_cnt;
          held = tx_data;
        end else if (tx_stb) begin
          check("tx_data_hold", 32'(tx_data), 32'(held));
        end
        prev_stb = tx_stb;
      end else begin
        prev_stb = 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rdata;
    int acks;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = '0;   wb.wbs_adr_i = '0;   wb.wbs_dat_i = '0;
    rx_pins = 8'h00;

    // Reset values, observed before any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("rst_oeb", 32'(tx_oeb), 32'h1FF);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_stb", 32'(tx_stb), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    wb_read(REG_STATUS, rdata);
    check("status_after_reset", rdata, 32'h0000_0001);
    wb_read(REG_CTRL, rdata);
    check("ctrl_after_reset", rdata, 32'h0);

    // Single byte through the handshake
    peer_delay = 3;
    set_ctrl(2'b01);
    push_byte(8'hA5, 4'h1);
    @(posedge clk); #1;
    check("stb_rise_after_ack", 32'(tx_stb), 32'd1);
    check("stb_data_a5", 32'(tx_data), 32'hA5);
    wait_drained(60);
    wb_read(REG_STATUS, rdata);
    check("status_after_a5", rdata, status_of(0, 1'b0, 1'b0));

    // Fill past DEPTH with the port disabled
    set_ctrl(2'b00);
    for (int i = 0; i < DEPTH + 1; i++) push_byte(8'(i), 4'h1);
    wb_read(REG_STATUS, rdata);
    check("status_full_ovf_literal", rdata, 32'h0000_0086);
    check("status_full_ovf_model", rdata, status_of(exp_q.size(), model_ovf, 1'b0));
    wb_read(REG_TXDATA, rdata);
    check("txdata_reads_zero", rdata, 32'h0);
    wb_write(REG_STATUS, 32'h0000_0004, 4'h1);
    model_ovf = 1'b0;
    wb_read(REG_STATUS, rdata);
    check("status_ovf_cleared", rdata, 32'h0000_0082);
    peer_delay = 1;
    set_ctrl(2'b11);
    wb_read(REG_CTRL, rdata);
    check("ctrl_readback", rdata, 32'h3);
    wait_drained(400);
    check("irq_empty_after_drain", 32'(irq), 32'd1);

    // Interrupt on empty, cleared by a push
    set_ctrl(2'b10);
    check("irq_empty_idle", 32'(irq), 32'd1);
    push_byte(8'h77, 4'h1);
    check("irq_after_push", 32'(irq), 32'd0);

    // Reset while a request is outstanding
    peer_on = 1'b0;
    set_ctrl(2'b11);
    for (int i = 0; i < 10 && !tx_stb; i++) begin @(posedge clk); #1; end
    check("stb_before_reset", 32'(tx_stb), 32'd1);
    repeat (2) @(posedge clk);
    #1 check("state_req", 32'(dbg_state), 32'(REQ));
    #1 rst_n = 1'b0;
    model_en = 1'b0; model_ovf = 1'b0; exp_q.delete();
    #1;
    check("async_rst_stb", 32'(tx_stb), 32'd0);
    check("async_rst_oeb", 32'(tx_oeb), 32'h1FF);
    check("async_rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #2 rst_n = 1'b1;
    peer_on = 1'b1;
    wb_read(REG_STATUS, rdata);
    check("status_after_mid_reset", rdata, 32'h0000_0001);

    // Input-pin synchronizer
    @(posedge clk); #1 rx_pins = 8'h3C;
    repeat (2) @(posedge clk);
    wb_read(REG_RXIN, rdata);
    check("rxin_3c", rdata, 32'h0000_003C);
    rx_pins = 8'h5A;
    wb_read(REG_RXIN, rdata);
    check("rxin_two_flop_delay", rdata, 32'h0000_003C);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] v;
      v = 8'($urandom);
      @(posedge clk); #1 rx_pins = v;
      repeat (2) @(posedge clk);
      wb_read(REG_RXIN, rdata);
      check("rxin_random", rdata, {24'h0, v});
    end

    // Non-matching address must never be acknowledged
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
    wb.wbs_adr_i = BASE + 32'h10; wb.wbs_sel_i = 4'hF;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) acks++;
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    check("no_ack_outside_window", 32'(acks), 32'd0);

    // Random traffic with a randomly slow peer
    set_ctrl(2'b01);
    for (int n = 0; n < 40; n++) begin
      peer_delay = $urandom_range(0, 3);
      if (exp_q.size() < DEPTH) push_byte(8'($urandom), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    wait_drained(1500);
    wb_read(REG_STATUS, rdata);
    check("status_after_random", rdata, status_of(0, 1'b0, 1'b0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
